path_dir_encoder: RTL and testbench
===================================

Name: path_dir_encoder

Overview:
- Sits directly downstream of the maze-solver datapath. Consumes the solved path as a stream of 8-bit {X,Y} cells (X = bits 7:4, Y = bits 3:0), from start cell through end cell.
- Converts each pair of consecutive cells into a 2-bit move direction. Buffers the directions in a small FIFO and hands them to the move-output/display stage over a valid/ready handshake.
- Also reports the step count, completion, and path-adjacency errors.

Parameters:
- FIFO_DEPTH, 4: number of direction entries buffered; power of two, 2..16.
- CNT_W, 8: width of the step counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; clears counters and flags and arms a new path.
- coord_in  in  8  path cell {X[3:0],Y[3:0]}.
- coord_valid  in  1  coord_in is valid this cycle.
- coord_last  in  1  qualifies coord_in as the final (end) cell; driven from the solver's end-of-path flag.
- coord_ready  out  1  encoder accepts coord_in this cycle; drives the solver controller's load/queue-advance.
- dir_out  out  2  direction: 0 up (Y+1), 1 right (X+1), 2 left (X-1), 3 down (Y-1).
- dir_valid  out  1  FIFO head valid.
- dir_ready  in  1  consumer takes dir_out.
- dir_last  out  1  head entry is the final move of the path.
- step_count  out  CNT_W  number of directions produced for the current path.
- done  out  1  level; final direction has been popped.
- error  out  1  level; sticky until start or rst.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, prev cell register 8'h00.
- Coordinate transfer occurs when coord_valid && coord_ready.
- FSM states:
  - IDLE: coord_ready=0. A start pulse goes to FIRST and clears step_count, done, error and the FIFO.
  - FIRST: coord_ready=1. On transfer, store the cell in prev and go to STEP. A transfer with coord_last=1 here means a single-cell path: no direction is produced, go to DONE, and done=1 on the next cycle.
  - STEP: coord_ready = !fifo_full. On transfer:
    - compute the direction from prev to coord_in;
    - push {dir, coord_last} into the FIFO;
    - prev <= coord_in;
    - step_count++ (saturating).
    - If coord_last=1, go to DRAIN.
  - DRAIN: coord_ready=0. When the FIFO becomes empty after popping the entry whose last flag is set, go to DONE.
  - DONE: done=1, coord_ready=0. Stay here until start, which re-enters FIRST.
  - ERROR: only reachable with the optional feature compiled in. coord_ready=0, dir_valid=0, error=1. Leaves on start or rst.
- Direction compute (combinational, 4-bit unsigned, no wrap-around):
  - X equal and Y+1 → 0.
  - Y equal and X+1 → 1.
  - Y equal and X-1 → 2.
  - X equal and Y-1 → 3.
  - X=15→0 or 0→15 (and the same for Y) is NOT adjacent.
- Latency: a direction is visible on dir_out one cycle after the transfer of its second cell (registered FIFO write; combinational head read).
- Output handshake:
  - Pop occurs on dir_valid && dir_ready.
  - dir_out and dir_last hold stable while dir_valid=1 and dir_ready=0.
  - Push and pop in the same cycle are both performed. When full, coord_ready stays 0 even if a pop occurs that cycle (no combinational ready-from-ready path).
- start while busy: aborts the path. The FIFO is flushed, outputs return to their cleared values next cycle, and the FSM enters FIRST.
- rst mid-operation: returns everything to reset state immediately.
- Simultaneous start and coord transfer: start wins and the coordinate is not consumed. coord_ready is forced to 0 in the cycle start is high.

Optional Feature:
- Macro: PATH_ADJ_CHECK_EN.
- Defined: a non-adjacent pair (any case not matched above, including identical cells) pushes nothing, sets error=1, and moves the FSM to ERROR. The FIFO is flushed.
- Undefined: no checking and error is tied to 0. Direction is chosen by priority: X equal and Y+1 → 0; else X+1 → 1; else X-1 → 2; else → 3.

Decomposition:
- Shared package path_pkg:
  - direction localparams DIR_UP=2'd0, DIR_RIGHT=2'd1, DIR_LEFT=2'd2, DIR_DOWN=2'd3 (same order as the solver's neighbour counter);
  - FSM state encodings (IDLE, FIRST, STEP, DRAIN, DONE, ERROR);
  - COORD_W=8, AXIS_W=4.
- Sub-module dir_fifo:
  - parameterised by FIFO_DEPTH; 3-bit entries {last, dir};
  - ports: flush, push, pop, full, empty, head data.
  - The FSM, direction compute and counters stay in path_dir_encoder.

Test Plan:
- Straight path 00,01,02,03 (last) with dir_ready=1 → dir_out 0,0,0. dir_last is set on the 3rd entry, step_count=3, done=1 after the pop, error=0.
- Mixed path 00,10,11,01,00 (last) → dirs 1,0,2,3; step_count=4.
- Backpressure: 6-step path with dir_ready=0 → coord_ready drops after 4 pushes (FIFO_DEPTH=4) and dir_out stays stable. Releasing dir_ready drains all 6 directions in order with no loss or duplication.
- Single-cell path: coord 00 with coord_last=1 in FIRST → no dir_valid, step_count=0, done=1.
- With PATH_ADJ_CHECK_EN: 0F→00 (Y wrap) → error=1, FSM in ERROR, coord_ready=0, nothing pushed. A start pulse clears error and the next path encodes normally. Without the macro, the same pair yields dir 3 and error stays 0.
- Abort: start pulse mid-path with 2 entries buffered, plus rst asserted asynchronously between clock edges mid-path → after the start, FIFO is empty, step_count=0, done=0 and the FSM is in FIRST. On rst, all outputs are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/path_pkg.sv
// Shared definitions for the path direction encoder: move codes, FSM states and the
// {last, dir} entry carried through the direction FIFO.
package path_pkg;

  localparam int COORD_W = 8;
  localparam int AXIS_W  = 4;

  // Same order as the solver's neighbour counter.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  typedef struct packed {
    logic       last;
    logic [1:0] dir;
  } dir_entry_t;

  // True when b is exactly a+1; evaluated one bit wider so 15 -> 0 never counts as a step.
  function automatic logic is_inc(input logic [AXIS_W-1:0] a, input logic [AXIS_W-1:0] b);
    return {1'b0, b} == ({1'b0, a} + (AXIS_W + 1)'(1));
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Direction FIFO: registered write, combinational head read (head reads zero when empty),
// one-cycle latency; push and pop may coincide, pushes into a full FIFO are dropped, flush overrides both.
module dir_fifo
  import path_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  dir_entry_t push_dat,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output dir_entry_t head_dat
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  dir_entry_t  mem_q [FIFO_DEPTH];
  dir_entry_t  mem_d [FIFO_DEPTH];
  logic        push_en;
  logic        pop_en;

  // Pointers carry a wrap bit so full and empty are distinguishable without a counter.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/path_dir_encoder.sv
// Turns the solved-path cell stream into 2-bit moves; a move is on dir_out one cycle after its cell is taken.
// coord_ready drops while the FIFO is full; build with PATH_ADJ_CHECK_EN to trap non-adjacent cells in ERROR.
module path_dir_encoder
  import path_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] coord_in,
  input  logic               coord_valid,
  input  logic               coord_last,
  output logic               coord_ready,
  output logic [1:0]         dir_out,
  output logic               dir_valid,
  input  logic               dir_ready,
  output logic               dir_last,
  output logic [CNT_W-1:0]   step_count,
  output logic               done,
  output logic               error
);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic               fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  dir_entry_t         push_dat, head_dat;
  logic [AXIS_W-1:0]  px, py, cx, cy;
  logic [1:0]         step_dir;
  logic               xfer;

  assign px = prev_q[COORD_W-1 -: AXIS_W];
  assign py = prev_q[AXIS_W-1:0];
  assign cx = coord_in[COORD_W-1 -: AXIS_W];
  assign cy = coord_in[AXIS_W-1:0];

`ifdef PATH_ADJ_CHECK_EN
  logic step_adj;

  always_comb begin
    step_adj = 1'b1;
    step_dir = DIR_UP;
    if (cx == px && is_inc(py, cy))      step_dir = DIR_UP;
    else if (cy == py && is_inc(px, cx)) step_dir = DIR_RIGHT;
    else if (cy == py && is_inc(cx, px)) step_dir = DIR_LEFT;
    else if (cx == px && is_inc(cy, py)) step_dir = DIR_DOWN;
    else                                 step_adj = 1'b0;
  end

  assign error = (state_q == ST_ERROR);
`else
  // Unchecked build: a priority pick, so any pair still yields some move.
  always_comb begin
    if (cx == px && is_inc(py, cy)) step_dir = DIR_UP;
    else if (is_inc(px, cx))        step_dir = DIR_RIGHT;
    else if (is_inc(cx, px))        step_dir = DIR_LEFT;
    else                            step_dir = DIR_DOWN;
  end

  assign error = 1'b0;
`endif

  assign push_dat   = '{last: coord_last, dir: step_dir};
  assign dir_valid  = !fifo_empty && (state_q != ST_ERROR);
  assign fifo_pop   = dir_valid && dir_ready;
  assign xfer       = coord_valid && coord_ready;
  assign dir_out    = head_dat.dir;
  assign dir_last   = head_dat.last;
  assign step_count = step_count_q;
  assign done       = (state_q == ST_DONE);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    step_count_d = step_count_q;
    fifo_flush   = 1'b0;
    fifo_push    = 1'b0;
    // Ready depends only on registered state and start, never on dir_ready.
    coord_ready  = !start && ((state_q == ST_FIRST) || (state_q == ST_STEP && !fifo_full));

    if (start) begin
      fifo_flush   = 1'b1;
      step_count_d = '0;
      state_d      = ST_FIRST;
    end else begin
      unique case (state_q)
        ST_FIRST: begin
          if (xfer) begin
            prev_d  = coord_in;
            state_d = coord_last ? ST_DONE : ST_STEP;
          end
        end
        ST_STEP: begin
          if (xfer) begin
`ifdef PATH_ADJ_CHECK_EN
            if (!step_adj) begin
              fifo_flush = 1'b1;
              state_d    = ST_ERROR;
            end else
`endif
            begin
              fifo_push = 1'b1;
              prev_d    = coord_in;
              if (step_count_q != '1) begin
                step_count_d = step_count_q + CNT_W'(1);
              end
              if (coord_last) begin
                state_d = ST_DRAIN;
              end
            end
          end
        end
        // Nothing is pushed after the last entry, so popping it empties the FIFO.
        ST_DRAIN: begin
          if (fifo_pop && head_dat.last) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      step_count_q <= step_count_d;
    end
  end

  dir_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dir_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .push_dat(push_dat),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head_dat(head_dat)
  );

endmodule

// File: tb/tb_path_dir_encoder.sv
// Scoreboarded bench for path_dir_encoder: directed and random paths, backpressure, abort and reset.
module tb_path_dir_encoder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] coord_in;
  logic       coord_valid;
  logic       coord_last;
  logic       coord_ready;
  logic [1:0] dir_out;
  logic       dir_valid;
  logic       dir_ready;
  logic       dir_last;
  logic [7:0] step_count;
  logic       done;
  logic       error;

  int         compared   = 0;
  int         mismatched = 0;
  int         ready_mode = 0;   // 0 always ready, 1 never ready, 2 random
  logic [7:0] path_q[$];
  logic [2:0] exp_q[$];         // {last, dir}
  logic       hold_vld = 1'b0;
  logic [2:0] hold_dat = '0;

  path_dir_encoder #(.FIFO_DEPTH(4), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coord_in   (coord_in),
    .coord_valid(coord_valid),
    .coord_last (coord_last),
    .coord_ready(coord_ready),
    .dir_out    (dir_out),
    .dir_valid  (dir_valid),
    .dir_ready  (dir_ready),
    .dir_last   (dir_last),
    .step_count (step_count),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (compared %0d)", compared);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: move from cell a to cell b from signed axis deltas.
  function automatic bit model_adj(input logic [7:0] a, input logic [7:0] b);
    int dx, dy;
    dx = int'(b[7:4]) - int'(a[7:4]);
    dy = int'(b[3:0]) - int'(a[3:0]);
    return ((dx == 0) && (dy == 1 || dy == -1)) || ((dy == 0) && (dx == 1 || dx == -1));
  endfunction

  function automatic logic [1:0] model_dir(input logic [7:0] a, input logic [7:0] b);
    int dx, dy;
    dx = int'(b[7:4]) - int'(a[7:4]);
    dy = int'(b[3:0]) - int'(a[3:0]);
    if (dx == 0 && dy == 1) return 2'd0;
    if (dx == 1)            return 2'd1;
    if (dx == -1)           return 2'd2;
    return 2'd3;
  endfunction

  initial begin
    dir_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dir_ready = 1'b1;
        1:       dir_ready = 1'b0;
        default: dir_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks head stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && dir_valid) chk("hold_stable", {dir_last, dir_out}, hold_dat);
      if (dir_valid && dir_ready) begin
        if (exp_q.size() == 0) chk("pop_without_expectation", dir_valid, 0);
        else                   chk("dir_entry", {dir_last, dir_out}, exp_q.pop_front());
      end
      hold_vld = dir_valid && !dir_ready && !start;
      hold_dat = {dir_last, dir_out};
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1;
    start       = 1'b1;
    coord_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Sends path_q[0..n-1]; marks the final one last when mark_last. Returns at posedge+1.
  task automatic send_cells(input int n, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      bit ok;
      int waited;
      ok          = 1'b0;
      waited      = 0;
      coord_in    = path_q[i];
      coord_valid = 1'b1;
      coord_last  = mark_last && (i == n - 1);
      while (!ok && waited < 500) begin
        @(negedge clk);
        if (coord_ready) ok = 1'b1;
        else             waited++;
      end
      chk("coord_accept_in_time", ok, 1);
      if (ok && i > 0) begin
`ifdef PATH_ADJ_CHECK_EN
        if (model_adj(path_q[i-1], path_q[i]))
`endif
          exp_q.push_back({coord_last, model_dir(path_q[i-1], path_q[i])});
      end
      @(posedge clk);
      #1;
    end
    coord_valid = 1'b0;
    coord_last  = 1'b0;
  endtask

  task automatic wait_done(input int exp_steps, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_steps"}, step_count, exp_steps);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_coord_ready"}, coord_ready, 0);
  endtask

  task automatic make_random_path(input int n);
    int x, y, d;
    bit moved;
    path_q.delete();
    x = $urandom_range(0, 15);
    y = $urandom_range(0, 15);
    path_q.push_back({4'(x), 4'(y)});
    for (int i = 1; i < n; i++) begin
      moved = 1'b0;
      while (!moved) begin
        d = $urandom_range(0, 3);
        case (d)
          0: if (y < 15) begin y++; moved = 1'b1; end
          1: if (x < 15) begin x++; moved = 1'b1; end
          2: if (x > 0)  begin x--; moved = 1'b1; end
          default: if (y > 0) begin y--; moved = 1'b1; end
        endcase
      end
      path_q.push_back({4'(x), 4'(y)});
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    coord_in    = '0;
    coord_valid = 1'b0;
    coord_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coord_ready", coord_ready, 0);
    chk("rst_dir_valid", dir_valid, 0);
    chk("rst_dir_out", dir_out, 0);
    chk("rst_dir_last", dir_last, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_coord_ready", coord_ready, 0);

    // Straight up, then a mixed loop back to the origin.
    ready_mode = 0;
    path_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    do_start();
    send_cells(4, 1);
    wait_done(3, "straight");

    path_q = '{8'h00, 8'h10, 8'h11, 8'h01, 8'h00};
    do_start();
    send_cells(5, 1);
    wait_done(4, "mixed");

    path_q = '{8'h00};
    do_start();
    send_cells(1, 1);
    wait_done(0, "single");

    // Backpressure: six moves, consumer stalled until the encoder has filled the FIFO.
    ready_mode = 1;
    path_q = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h31, 8'h32, 8'h33};
    do_start();
    fork
      send_cells(7, 1);
      begin
        repeat (20) @(negedge clk);
        chk("bp_coord_ready", coord_ready, 0);
        chk("bp_step_count", step_count, 4);
        chk("bp_dir_valid", dir_valid, 1);
        chk("bp_head", {dir_last, dir_out}, 3'b001);
        ready_mode = 0;
      end
    join
    wait_done(6, "backpressure");

    // Y wrap 0F -> 00 is not a neighbour.
    path_q = '{8'h0F, 8'h00};
    do_start();
    send_cells(2, 1);
`ifdef PATH_ADJ_CHECK_EN
    @(negedge clk);
    chk("wrap_error", error, 1);
    chk("wrap_coord_ready", coord_ready, 0);
    chk("wrap_dir_valid", dir_valid, 0);
    chk("wrap_step_count", step_count, 0);
    do_start();
    @(negedge clk);
    chk("wrap_error_cleared", error, 0);
    path_q = '{8'h55, 8'h45};
    send_cells(2, 1);
    wait_done(1, "after_error");
`else
    wait_done(1, "wrap");
`endif

    // Counter saturation on a long zig-zag.
    path_q.delete();
    for (int i = 0; i < 301; i++) path_q.push_back((i % 2 == 0) ? 8'h00 : 8'h10);
    do_start();
    send_cells(301, 1);
    wait_done(255, "saturate");

    // Abort with two entries buffered, then asynchronous reset mid-path.
    ready_mode = 1;
    path_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    do_start();
    send_cells(3, 0);
    @(negedge clk);
    chk("abort_pre_dir_valid", dir_valid, 1);
    chk("abort_pre_steps", step_count, 2);
    do_start();
    exp_q.delete();
    @(negedge clk);
    chk("abort_dir_valid", dir_valid, 0);
    chk("abort_steps", step_count, 0);
    chk("abort_done", done, 0);
    chk("abort_first_ready", coord_ready, 1);
    send_cells(3, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_dir_valid", dir_valid, 0);
    chk("arst_coord_ready", coord_ready, 0);
    chk("arst_dir_out", {dir_last, dir_out}, 0);
    chk("arst_step_count", step_count, 0);
    chk("arst_done_error", {done, error}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_ready", coord_ready, 0);

    // Random paths with a randomly stalling consumer.
    ready_mode = 2;
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 12);
      make_random_path(n);
      do_start();
      send_cells(n, 1);
      wait_done(n - 1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
